axi_wr_rsp_gen: RTL

- Slave-side AXI write-response (B channel) generator; drives the slave modport of the write-response channel interface.
- Accepts write-completion events from the slave write datapath (one per finished burst), queues them in order, and presents them as B beats with full valid/ready handshake.
- Sits between the slave write engine and the interconnect/master. Decouples completion timing from master back-pressure.

---
 rtl/axi_pkg.sv | 13 +
 rtl/axi_wr_rsp_gen_if.sv | 10 +
 rtl/sync_fifo_reg.sv | 42 ++++
 rtl/axi_wr_rsp_gen.sv | 56 +++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI response codes and B-channel payload types shared by the write-response path.
package axi_pkg;
  localparam int unsigned AXI_ID_W = 16;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} axi_resp_e;
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    axi_resp_e           resp;
    logic                user;
  } b_rsp_t;
  function automatic logic is_err(axi_resp_e r);
    return r[1];
  endfunction
endpackage

// File: rtl/axi_wr_rsp_gen_if.sv
// axi_wr_rsp_gen_if: AXI write-response (B) channel with master/slave views.
interface axi_wr_rsp_gen_if #(parameter int ID_MAX_WIDTH = 16);
  logic                    bvalid;
  logic                    bready;
  logic [ID_MAX_WIDTH-1:0] bid;
  logic [1:0]              bresp;
  logic                    buser;
  modport slave  (output bvalid, bid, bresp, buser, input bready);
  modport master (input bvalid, bid, bresp, buser, output bready);
endinterface

// File: rtl/sync_fifo_reg.sv
// sync_fifo_reg: flop-based in-order FIFO; full/empty come from the occupancy count, pointers wrap naturally.
module sync_fifo_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/axi_wr_rsp_gen.sv
// axi_wr_rsp_gen: queues write completions and returns them in order as AXI B beats.
// Define AXI_WR_RSP_ERR_CNT_EN to add a saturating err_cnt of SLVERR/DECERR handshakes.
module axi_wr_rsp_gen
  import axi_pkg::*;
#(
  parameter int ID_MAX_WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmp_valid,
  output logic                    cmp_ready,
  input  logic [ID_MAX_WIDTH-1:0] cmp_id,
  input  logic [1:0]              cmp_resp,
  input  logic                    cmp_user,
  axi_wr_rsp_gen_if.slave         b_if,
  output logic [CNT_W-1:0]        rsp_cnt
`ifdef AXI_WR_RSP_ERR_CNT_EN
  ,
  output logic [15:0]             err_cnt
`endif
);
  typedef struct packed {
    logic [ID_MAX_WIDTH-1:0] id;
    axi_resp_e               resp;
    logic                    user;
  } rsp_t;
  rsp_t wr_rsp, head;
  logic full, empty;
  assign wr_rsp = '{id: cmp_id, resp: axi_resp_e'(cmp_resp), user: cmp_user};
  sync_fifo_reg #(.WIDTH($bits(rsp_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmp_valid),
    .pop_i   (b_if.bready),
    .wdata_i (wr_rsp),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (rsp_cnt)
  );
  // Payload is masked to zero whenever no beat is offered.
  assign cmp_ready   = !full;
  assign b_if.bvalid = !empty;
  assign b_if.bid    = empty ? '0 : head.id;
  assign b_if.bresp  = empty ? '0 : head.resp;
  assign b_if.buser  = empty ? 1'b0 : head.user;
`ifdef AXI_WR_RSP_ERR_CNT_EN
  logic [15:0] err_q, err_d;
  assign err_d = (b_if.bvalid && b_if.bready && is_err(head.resp) && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  always_ff @(posedge clk)
    err_q <= !rst_n ? '0 : err_d;
  assign err_cnt = err_q;
`endif
endmodule
